// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the execute stage.
//   DATA_W / PC_W / REG_W : datapath, program-counter and register-index widths
//   alu_op_t              : 3-bit ALU opcode
//   ex_mem_t              : contents of the EX/MEM pipeline register
//   is_dep()              : true when a source index depends on a destination index
//   fwd_sel()             : operand forwarding priority (MEM over WB over ID/EX)
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 10;
  localparam int REG_W  = 4;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLL   = 3'd5,
    ALU_SRL   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic              br_taken;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dst;
    logic [PC_W-1:0]   br_target;
    logic              zero;
  } ex_mem_t;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  function automatic logic is_dep(input logic [REG_W-1:0] src,
                                  input logic [REG_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  // mem_ok: the MEM-stage instruction writes a register and is not a load
  // (load data is not available until WB).
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] id_val,
    input logic              mem_ok,
    input logic [REG_W-1:0]  mem_dst,
    input logic [DATA_W-1:0] mem_val,
    input logic              wb_en,
    input logic [REG_W-1:0]  wb_dst,
    input logic [DATA_W-1:0] wb_val
  );
    logic [DATA_W-1:0] v;
    v = id_val;
    if (mem_ok && is_dep(idx, mem_dst))    v = mem_val;
    else if (wb_en && is_dep(idx, wb_dst)) v = wb_val;
    return v;
  endfunction

endpackage

// File: rtl/ex_stage_alu16.sv
// alu16: purely combinational 16-bit ALU.
//   i_op   : ALU opcode (alu_op_t encoding)
//   i_a    : operand A
//   i_b    : operand B; shifts use i_b[3:0] as the amount
//   o_y    : result, ADD/SUB wrap modulo 2^16
//   o_zero : o_y == 0
module alu16
  import pipe_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y,
  output logic              o_zero
);

  always_comb begin
    o_y = '0;
    case (alu_op_t'(i_op))
      ALU_ADD:   o_y = i_a + i_b;
      ALU_SUB:   o_y = i_a - i_b;
      ALU_AND:   o_y = i_a & i_b;
      ALU_OR:    o_y = i_a | i_b;
      ALU_XOR:   o_y = i_a ^ i_b;
      ALU_SLL:   o_y = i_a << i_b[3:0];
      ALU_SRL:   o_y = i_a >> i_b[3:0];
      ALU_PASSB: o_y = i_b;
      default:   o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage sitting between the ID/EX and EX/MEM registers.
// Forwards operands from MEM/WB, evaluates the ALU and branch target, owns
// the load-use interlock and holds the EX/MEM register.
// Build option: define FORWARDING_EN to enable the MEM/WB forwarding muxes;
// without it every dependency on MEM or WB stalls instead.
// Ports:
//   Clk, rst               clock, synchronous active-high reset
//   WBEnable..DstReg       ID/EX register contents
//   Stall_In               MEM busy, hold EX/MEM
//   Flush                  squash the instruction in EX
//   WB_Dst/WB_En/WB_Value  WB-stage write port
//   Stall_Out              combinational freeze of PC, IF/ID and ID/EX
//   WBEnableOut..ZeroFlag  EX/MEM register contents
// Stall semantics: Stall_Out = 1 means upstream must present the same EX
// instruction again next cycle; Stall_In = 1 means EX/MEM keeps every field
// and the EX instruction stays pending. Reset forces Stall_Out low.
module ex_stage
  import pipe_pkg::*;
(
  input  logic              Clk,
  input  logic              rst,
  input  logic              WBEnable,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              Br_TakenIn,
  input  logic [2:0]        ALUOperation,
  input  logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] Val1,
  input  logic [DATA_W-1:0] Val2,
  input  logic [DATA_W-1:0] Reg2,
  input  logic [REG_W-1:0]  Src1,
  input  logic [REG_W-1:0]  Src2,
  input  logic [REG_W-1:0]  DstReg,
  input  logic              Stall_In,
  input  logic              Flush,
  input  logic [REG_W-1:0]  WB_Dst,
  input  logic              WB_En,
  input  logic [DATA_W-1:0] WB_Value,
  output logic              Stall_Out,
  output logic              WBEnableOut,
  output logic              MemReadOut,
  output logic              MemWriteOut,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] StoreData,
  output logic [REG_W-1:0]  DstRegOut,
  output logic              BranchTaken,
  output logic [PC_W-1:0]   BranchTarget,
  output logic              ZeroFlag
);

  ex_mem_t           r_q;
  ex_mem_t           w_next;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_store;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_zero;
  logic              w_hazard;

`ifdef FORWARDING_EN
  logic w_mem_ok;
  assign w_mem_ok = r_q.wb_en && !r_q.mem_read;

  // Store data shares Src2 with operand B but forwards into Reg2.
  assign w_op_a  = fwd_sel(Src1, Val1, w_mem_ok, r_q.dst, r_q.alu_result, WB_En, WB_Dst, WB_Value);
  assign w_op_b  = fwd_sel(Src2, Val2, w_mem_ok, r_q.dst, r_q.alu_result, WB_En, WB_Dst, WB_Value);
  assign w_store = fwd_sel(Src2, Reg2, w_mem_ok, r_q.dst, r_q.alu_result, WB_En, WB_Dst, WB_Value);

  // Only a load in MEM cannot be forwarded; it resolves one cycle later via WB.
  assign w_hazard = r_q.mem_read && (is_dep(Src1, r_q.dst) || is_dep(Src2, r_q.dst));
`else
  logic w_unused;
  assign w_unused = ^WB_Value;

  assign w_op_a  = Val1;
  assign w_op_b  = Val2;
  assign w_store = Reg2;

  // Wait until the producer has retired through WB into the register file.
  assign w_hazard = (r_q.wb_en && (is_dep(Src1, r_q.dst) || is_dep(Src2, r_q.dst))) ||
                    (WB_En     && (is_dep(Src1, WB_Dst)   || is_dep(Src2, WB_Dst)));
`endif

  alu16 u_alu (
    .i_op   (ALUOperation),
    .i_a    (w_op_a),
    .i_b    (w_op_b),
    .o_y    (w_alu_y),
    .o_zero (w_alu_zero)
  );

  always_comb begin
    w_next            = '0;
    w_next.wb_en      = WBEnable;
    w_next.mem_read   = MemReadIn;
    w_next.mem_write  = MemWriteIn;
    w_next.br_taken   = Br_TakenIn;
    w_next.alu_result = w_alu_y;
    w_next.store_data = w_store;
    w_next.dst        = DstReg;
    w_next.br_target  = PC + Val2[PC_W-1:0];
    w_next.zero       = w_alu_zero;
    // Bubble: only the control bits matter, data fields are don't-care.
    if (Flush || w_hazard) begin
      w_next.wb_en     = 1'b0;
      w_next.mem_read  = 1'b0;
      w_next.mem_write = 1'b0;
      w_next.br_taken  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (rst)            r_q <= '0;
    else if (!Stall_In) r_q <= w_next;
  end

  // A flushed instruction must not hold the pipe even if it had a hazard.
  assign Stall_Out = !rst && (Stall_In || (!Flush && w_hazard));

  assign WBEnableOut  = r_q.wb_en;
  assign MemReadOut   = r_q.mem_read;
  assign MemWriteOut  = r_q.mem_write;
  assign ALUResult    = r_q.alu_result;
  assign StoreData    = r_q.store_data;
  assign DstRegOut    = r_q.dst;
  assign BranchTaken  = r_q.br_taken;
  assign BranchTarget = r_q.br_target;
  assign ZeroFlag     = r_q.zero;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import pipe_pkg::*;

  // ---------------- clock / DUT signals ----------------
  logic        Clk, rst;
  logic        WBEnable, MemReadIn, MemWriteIn, Br_TakenIn;
  logic [2:0]  ALUOperation;
  logic [9:0]  PC;
  logic [15:0] Val1, Val2, Reg2;
  logic [3:0]  Src1, Src2, DstReg;
  logic        Stall_In, Flush;
  logic [3:0]  WB_Dst;
  logic        WB_En;
  logic [15:0] WB_Value;
  logic        Stall_Out, WBEnableOut, MemReadOut, MemWriteOut;
  logic [15:0] ALUResult, StoreData;
  logic [3:0]  DstRegOut;
  logic        BranchTaken;
  logic [9:0]  BranchTarget;
  logic        ZeroFlag;

  ex_stage dut (
    .Clk(Clk), .rst(rst), .WBEnable(WBEnable), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .Br_TakenIn(Br_TakenIn), .ALUOperation(ALUOperation),
    .PC(PC), .Val1(Val1), .Val2(Val2), .Reg2(Reg2), .Src1(Src1), .Src2(Src2),
    .DstReg(DstReg), .Stall_In(Stall_In), .Flush(Flush), .WB_Dst(WB_Dst),
    .WB_En(WB_En), .WB_Value(WB_Value), .Stall_Out(Stall_Out),
    .WBEnableOut(WBEnableOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .ALUResult(ALUResult), .StoreData(StoreData), .DstRegOut(DstRegOut),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .ZeroFlag(ZeroFlag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        bubble;
    logic        wb, mr, mw, bt;
    logic [15:0] alu, st;
    logic [3:0]  dst;
    logic [9:0]  tgt;
    logic        z;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m, m_prev, mon_e;
  logic [15:0] load_data;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic dep(input logic [3:0] s, input logic [3:0] d);
    return (s != 4'd0) && (s == d);
  endfunction

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] p;
    int          sh;
    sh = int'(b[3:0]);
    case (op)
      3'd0: p = 32'(a) + 32'(b);
      3'd1: p = 32'(a) + 32'h10000 - 32'(b);
      3'd2: p = 32'(a & b);
      3'd3: p = 32'(a | b);
      3'd4: p = 32'(a ^ b);
      3'd5: p = 32'(a) * (32'd1 << sh);
      3'd6: p = 32'(a) / (32'd1 << sh);
      default: p = 32'(b);
    endcase
    return p[15:0];
  endfunction

  // The newest in-flight producer of a register wins; a load in MEM has no value yet.
  function automatic logic [15:0] fwd_ref(input logic [3:0] idx, input logic [15:0] id_val);
    if (idx == 4'd0) return id_val;
    if (m.wb && !m.mr && m.dst == idx) return m.alu;
    if (WB_En && WB_Dst == idx) return WB_Value;
    return id_val;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [2:0] op, input logic [15:0] v1, input logic [15:0] v2,
                           input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                           input logic wb, input logic mr, input logic bt, input logic [9:0] pc);
    ALUOperation = op; Val1 = v1; Val2 = v2; Reg2 = 16'($urandom);
    Src1 = s1; Src2 = s2; DstReg = d;
    WBEnable = wb; MemReadIn = mr; MemWriteIn = 1'b0; Br_TakenIn = bt; PC = pc;
  endtask

  task automatic rand_instr();
    ALUOperation = 3'($urandom_range(0, 7));
    Val1 = 16'($urandom); Val2 = 16'($urandom); Reg2 = 16'($urandom);
    if ($urandom_range(0, 7) == 0) begin ALUOperation = 3'd1; Val2 = Val1; end
    Src1 = 4'($urandom_range(0, 7)); Src2 = 4'($urandom_range(0, 7));
    DstReg = 4'($urandom_range(0, 7));
    MemReadIn  = ($urandom_range(0, 3) == 0);
    MemWriteIn = !MemReadIn && ($urandom_range(0, 5) == 0);
    WBEnable   = MemReadIn || (!MemWriteIn && ($urandom_range(0, 4) != 0));
    Br_TakenIn = ($urandom_range(0, 5) == 0);
    PC = 10'($urandom);
  endtask

  // One cycle: drive at negedge, check Stall_Out, push the expected EX/MEM contents.
  task automatic step(input logic rst_v, input logic follow, output logic held);
    exp_t        nx;
    logic        hz, exp_stall;
    logic [15:0] a, b, sd;
    @(negedge Clk);
    rst = rst_v;
    if (follow) begin
      WB_En    = m_prev.wb;
      WB_Dst   = m_prev.dst;
      WB_Value = m_prev.mr ? load_data : m_prev.alu;
    end
    #1;
`ifdef FORWARDING_EN
    a  = fwd_ref(Src1, Val1);
    b  = fwd_ref(Src2, Val2);
    sd = fwd_ref(Src2, Reg2);
    hz = m.mr && (dep(Src1, m.dst) || dep(Src2, m.dst));
`else
    a  = Val1;
    b  = Val2;
    sd = Reg2;
    hz = (m.wb && (dep(Src1, m.dst) || dep(Src2, m.dst))) ||
         (WB_En && (dep(Src1, WB_Dst) || dep(Src2, WB_Dst)));
`endif
    exp_stall = !rst_v && (Stall_In || (!Flush && hz));
    chk("stall_out", {31'd0, Stall_Out}, {31'd0, exp_stall});
    if (rst_v) nx = '0;
    else if (Stall_In) nx = m;
    else begin
      nx.alu = alu_ref(ALUOperation, a, b);
      nx.z   = (nx.alu == 16'd0);
      nx.st  = sd;
      nx.dst = DstReg;
      nx.tgt = 10'((int'(PC) + int'(Val2[9:0])) % 1024);
      if (Flush || hz) begin
        nx.bubble = 1'b1; nx.wb = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0; nx.bt = 1'b0;
      end else begin
        nx.bubble = 1'b0; nx.wb = WBEnable; nx.mr = MemReadIn;
        nx.mw = MemWriteIn; nx.bt = Br_TakenIn;
      end
    end
    held   = exp_stall;
    m_prev = m;
    m      = nx;
    exp_q.push_back(nx);
    @(posedge Clk);
    #2;
  endtask

  // Repeats the current instruction while upstream is told to hold it.
  task automatic issue(input logic follow, output int nstall);
    logic held;
    nstall = 0;
    step(1'b0, follow, held);
    while (held && nstall < 6) begin
      nstall++;
      step(1'b0, follow, held);
    end
    if (held) chk("stall_bound", 32'd1, 32'd0);
  endtask

  // ---------------- monitor ----------------
  always begin
    @(posedge Clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ctrl", {28'd0, WBEnableOut, MemReadOut, MemWriteOut, BranchTaken},
                  {28'd0, mon_e.wb, mon_e.mr, mon_e.mw, mon_e.bt});
      if (!mon_e.bubble) begin
        chk("alu_result", {16'd0, ALUResult}, {16'd0, mon_e.alu});
        chk("store_data", {16'd0, StoreData}, {16'd0, mon_e.st});
        chk("dst_reg",    {28'd0, DstRegOut}, {28'd0, mon_e.dst});
        chk("br_target",  {22'd0, BranchTarget}, {22'd0, mon_e.tgt});
        chk("zero_flag",  {31'd0, ZeroFlag}, {31'd0, mon_e.z});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic held;
    int   ns;
    m = '0; m_prev = '0; load_data = 16'h00AA;
    rst = 1'b1; Stall_In = 1'b0; Flush = 1'b0;
    WB_En = 1'b0; WB_Dst = 4'd0; WB_Value = 16'd0;
    rand_instr();

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      rand_instr();
      Stall_In = 1'($urandom); Flush = 1'($urandom);
      WB_En = 1'($urandom); WB_Dst = 4'($urandom); WB_Value = 16'($urandom);
      step(1'b1, 1'b0, held);
    end
    chk("rst_alu", {16'd0, ALUResult}, 32'd0);
    chk("rst_wb", {31'd0, WBEnableOut}, 32'd0);
    Stall_In = 1'b0; Flush = 1'b0; WB_En = 1'b0;

    // ADD wrap into bit 15.
    set_instr(3'd0, 16'h7FFF, 16'h0001, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 10'd0);
    issue(1'b0, ns);
    chk("add_result", {16'd0, ALUResult}, 32'h8000);
    chk("add_wb", {31'd0, WBEnableOut}, 32'd1);
    chk("add_zero", {31'd0, ZeroFlag}, 32'd0);

    // SUB depends on r3 in MEM; WB also offers r3 but MEM wins.
    set_instr(3'd1, 16'h0000, 16'h0001, 4'd3, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0, 10'd0);
    WB_En = 1'b1; WB_Dst = 4'd3; WB_Value = 16'h1111;
    step(1'b0, 1'b0, held);
`ifdef FORWARDING_EN
    chk("sub_fwd_mem", {16'd0, ALUResult}, 32'h7FFF);
`else
    chk("sub_stall", {31'd0, held}, 32'd1);
`endif
    while (held && ns < 6) begin ns++; step(1'b0, 1'b1, held); end

    // Load-use interlock on r5.
    set_instr(3'd0, 16'h0040, 16'h0002, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 10'd0);
    issue(1'b1, ns);
    set_instr(3'd0, 16'h0000, 16'h5555, 4'd0, 4'd5, 4'd6, 1'b1, 1'b0, 1'b0, 10'd0);
    issue(1'b1, ns);
`ifdef FORWARDING_EN
    chk("load_use_stalls", ns, 32'd1);
    chk("load_use_fwd_wb", {16'd0, ALUResult}, 32'h00AA);
`else
    chk("load_use_stalls", ns, 32'd2);
`endif

    // Branch target wrap, then the same branch flushed.
    set_instr(3'd0, 16'h0000, 16'h0020, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 10'h3F0);
    issue(1'b1, ns);
    chk("br_target_wrap", {22'd0, BranchTarget}, 32'h010);
    chk("br_taken", {31'd0, BranchTaken}, 32'd1);
    Flush = 1'b1;
    step(1'b0, 1'b1, held);
    chk("br_flushed", {31'd0, BranchTaken}, 32'd0);
    Flush = 1'b0;

    // Stall_In holds EX/MEM for 3 cycles; pending instruction loads once.
    set_instr(3'd0, 16'h0100, 16'h0000, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 10'd0);
    issue(1'b1, ns);
    set_instr(3'd0, 16'h1234, 16'h0001, 4'd0, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 10'd0);
    Stall_In = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, held);
      chk("stall_in_hold", {16'd0, ALUResult}, 32'h0100);
    end
    Stall_In = 1'b0;
    issue(1'b1, ns);
    chk("stall_release", {16'd0, ALUResult}, 32'h1235);
    set_instr(3'd7, 16'h0000, 16'h00F0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 10'd0);
    issue(1'b1, ns);
    chk("after_release", {16'd0, ALUResult}, 32'h00F0);

    // Randomized traffic with stalls, flushes and pipelined WB.
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) rand_instr();
      Stall_In  = ($urandom_range(0, 7) == 0);
      Flush     = ($urandom_range(0, 9) == 0);
      load_data = 16'($urandom);
      step(1'b0, 1'b1, held);
    end
    Stall_In = 1'b0; Flush = 1'b0;

    repeat (2) @(posedge Clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
